cdb_arbiter: RTL and testbench

- Producer end of the common data bus (CDB) in the Tomasulo core. It drives the BCEN/BClabel/BCdata broadcast that the register file and the reservation stations snoop.
- Collects completed results from N_SRC functional units, each tagged with its reservation-station label.
- Buffers one result per source and issues at most one broadcast per cycle, chosen by round-robin arbitration.
- Label 0 means "no producer"; the block never broadcasts it.

---
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common data bus producer. Each functional unit has a
//               one-entry holding slot. A round-robin arbiter picks at most
//               one occupied slot per cycle and drives the registered
//               BCEN/BClabel/BCdata broadcast. Label 0 means "no producer":
//               results that carry it are accepted and then dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int N_SRC   = 4,
  parameter int LABEL_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic                       clk,
  input  logic                       nRST,
  input  logic [N_SRC-1:0]           src_valid,
  output logic [N_SRC-1:0]           src_ready,
  input  logic [N_SRC*LABEL_W-1:0]   src_label,
  input  logic [N_SRC*DATA_W-1:0]    src_data,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata
);

  localparam int                c_PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(N_SRC - 1);

  // Holding slots, round-robin pointer and broadcast registers
  logic [N_SRC-1:0]   r_holdV;
  logic [LABEL_W-1:0] r_holdLabel [N_SRC];
  logic [DATA_W-1:0]  r_holdData  [N_SRC];
  logic [c_PTR_W-1:0] r_rrPtr;
  logic               r_bcEn;
  logic [LABEL_W-1:0] r_bcLabel;
  logic [DATA_W-1:0]  r_bcData;

  // Arbitration results
  logic               w_found;
  logic [c_PTR_W-1:0] w_win;
  logic [c_PTR_W-1:0] w_nextPtr;
  logic [N_SRC-1:0]   w_grant;
  logic [N_SRC-1:0]   w_accept;

  // Round-robin search: first occupied slot at or after r_rrPtr, with wrap
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      int j;
      j = int'(r_rrPtr) + k;
      if (j >= N_SRC) j = j - N_SRC;
      if (!w_found && r_holdV[j]) begin
        w_found = 1'b1;
        w_win   = c_PTR_W'(j);
      end
    end
  end

  // One-hot grant and the pointer value that follows the winner
  always_comb begin
    w_grant = '0;
    if (w_found) w_grant[w_win] = 1'b1;
    w_nextPtr = (w_win == c_LAST) ? '0 : w_win + 1'b1;
  end

  // Ready comes only from registered state: empty slot, or slot draining now
  generate
    for (genvar i = 0; i < N_SRC; i++) begin : g_ready
      assign src_ready[i] = !r_holdV[i] || w_grant[i];
      assign w_accept[i]  = src_valid[i] && src_ready[i];
    end
  endgenerate

  // Slot update: capture accepted non-zero labels, otherwise release on grant
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_holdV <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        r_holdLabel[i] <= '0;
        r_holdData[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (w_accept[i] && (src_label[i*LABEL_W +: LABEL_W] != '0)) begin
          r_holdV[i]     <= 1'b1;
          r_holdLabel[i] <= src_label[i*LABEL_W +: LABEL_W];
          r_holdData[i]  <= src_data[i*DATA_W +: DATA_W];
        end else if (w_grant[i]) begin
          r_holdV[i] <= 1'b0;
        end
      end
    end
  end

  // Broadcast registers and pointer advance; idle cycles drive zeros
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_rrPtr   <= '0;
      r_bcEn    <= 1'b0;
      r_bcLabel <= '0;
      r_bcData  <= '0;
    end else if (w_found) begin
      r_rrPtr   <= w_nextPtr;
      r_bcEn    <= 1'b1;
      r_bcLabel <= r_holdLabel[w_win];
      r_bcData  <= r_holdData[w_win];
    end else begin
      r_bcEn    <= 1'b0;
      r_bcLabel <= '0;
      r_bcData  <= '0;
    end
  end

  assign BCEN    = r_bcEn;
  assign BClabel = r_bcLabel;
  assign BCdata  = r_bcData;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter (N_SRC=4,
//               LABEL_W=5, DATA_W=32) with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N_SRC   = 4;
  localparam int LABEL_W = 5;
  localparam int DATA_W  = 32;

  logic                     clk;
  logic                     nRST;
  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC-1:0]         src_ready;
  logic [N_SRC*LABEL_W-1:0] src_label;
  logic [N_SRC*DATA_W-1:0]  src_data;
  logic                     BCEN;
  logic [LABEL_W-1:0]       BClabel;
  logic [DATA_W-1:0]        BCdata;

  int total;
  int bad;

  cdb_arbiter #(
    .N_SRC  (N_SRC),
    .LABEL_W(LABEL_W),
    .DATA_W (DATA_W)
  ) u_dut (
    .clk      (clk),
    .nRST     (nRST),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_label(src_label),
    .src_data (src_data),
    .BCEN     (BCEN),
    .BClabel  (BClabel),
    .BCdata   (BCdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic [LABEL_W-1:0] lab, input logic [DATA_W-1:0] dat);
    src_valid[i] = 1'b1;
    src_label[i*LABEL_W +: LABEL_W] = lab;
    src_data[i*DATA_W +: DATA_W]    = dat;
  endtask

  task automatic idle_all();
    src_valid = '0;
    src_label = '0;
    src_data  = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
  endtask

  task automatic chk_bc(input string tag, input logic en, input logic [LABEL_W-1:0] lab);
    chk({tag, "_en"}, 64'(BCEN), 64'(en));
    chk({tag, "_label"}, 64'(BClabel), 64'(lab));
  endtask

  initial begin
    int n0;
    int n2;
    logic e0;
    logic e2;
    total = 0;
    bad   = 0;
    nRST  = 1'b1;
    idle_all();
    #1;
    nRST = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_bcen", 64'(BCEN), 64'd0);
    chk("rst_label", 64'(BClabel), 64'd0);
    chk("rst_data", 64'(BCdata), 64'd0);
    chk("rst_ready", 64'(src_ready), 64'hF);
    nRST = 1'b1;
    tick();

    // ---- Single source 1, label 3, one-cycle valid
    drive(1, 5'd3, 32'hDEADBEEF);
    chk("t1_ready1", 64'(src_ready[1]), 64'd1);
    tick();
    idle_all();
    chk_bc("t1_c1", 1'b0, 5'd0);
    tick();
    chk_bc("t1_c2", 1'b1, 5'd3);
    chk("t1_c2_data", 64'(BCdata), 64'hDEADBEEF);
    tick();
    chk_bc("t1_c3", 1'b0, 5'd0);
    chk("t1_c3_data", 64'(BCdata), 64'd0);

    // ---- All four sources in one cycle, labels 1..4
    do_reset();
    for (int i = 0; i < N_SRC; i++) drive(i, 5'(i + 1), 32'h100 + i);
    chk("t2_ready_all", 64'(src_ready), 64'hF);
    tick();
    idle_all();
    chk("t2_ready_c1", 64'(src_ready), 64'b0001);
    chk_bc("t2_c1", 1'b0, 5'd0);
    tick();
    chk_bc("t2_b1", 1'b1, 5'd1);
    chk("t2_b1_data", 64'(BCdata), 64'h100);
    chk("t2_ready_b1", 64'(src_ready), 64'b0011);
    tick();
    chk_bc("t2_b2", 1'b1, 5'd2);
    chk("t2_ready_b2", 64'(src_ready), 64'b0111);
    tick();
    chk_bc("t2_b3", 1'b1, 5'd3);
    chk("t2_ready_b3", 64'(src_ready), 64'b1111);
    tick();
    chk_bc("t2_b4", 1'b1, 5'd4);
    chk("t2_b4_data", 64'(BCdata), 64'h103);
    tick();
    chk_bc("t2_idle", 1'b0, 5'd0);

    // ---- Sources 0 and 2 continuously valid (pointer left at 0 by previous test)
    n0 = 5;
    n2 = 9;
    for (int k = 0; k < 7; k++) begin
      drive(0, 5'(n0), 32'(n0));
      drive(2, 5'(n2), 32'(n2));
      e0 = (k == 0) || (k % 2 == 1);
      e2 = (k == 0) || (k % 2 == 0);
      chk("t3_ready0", 64'(src_ready[0]), 64'(e0));
      chk("t3_ready2", 64'(src_ready[2]), 64'(e2));
      tick();
      if (k == 0) begin
        chk_bc("t3_first", 1'b0, 5'd0);
      end else if (k % 2 == 1) begin
        chk_bc("t3_src0", 1'b1, 5'(5 + (k - 1) / 2));
      end else begin
        chk_bc("t3_src2", 1'b1, 5'(9 + (k - 2) / 2));
      end
      if (e0) n0++;
      if (e2) n2++;
    end
    idle_all();

    // ---- Label 0 is accepted and dropped
    do_reset();
    tick();
    drive(3, 5'd0, 32'h1234);
    chk("t4_ready3", 64'(src_ready[3]), 64'd1);
    tick();
    idle_all();
    chk("t4_hold_empty", 64'(src_ready[3]), 64'd1);
    chk_bc("t4_c1", 1'b0, 5'd0);
    tick();
    chk_bc("t4_c2", 1'b0, 5'd0);
    tick();
    chk_bc("t4_c3", 1'b0, 5'd0);

    // ---- Reset pulse after the first broadcast
    for (int i = 0; i < N_SRC; i++) drive(i, 5'(i + 1), 32'h200 + i);
    tick();
    idle_all();
    tick();
    chk_bc("t5_b1", 1'b1, 5'd1);
    nRST = 1'b0;
    #1;
    chk("t5_async_bcen", 64'(BCEN), 64'd0);
    chk("t5_async_ready", 64'(src_ready), 64'hF);
    #1;
    nRST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t5_no_bc", 64'(BCEN), 64'd0);
    end
    chk("t5_ready_after", 64'(src_ready), 64'hF);

    // ---- Source 1 refilled on the edge it is granted
    do_reset();
    drive(1, 5'd5, 32'h55);
    tick();
    idle_all();
    drive(1, 5'd7, 32'h77);
    drive(0, 5'd8, 32'h88);
    chk("t6_ready1_granted", 64'(src_ready[1]), 64'd1);
    chk("t6_ready0", 64'(src_ready[0]), 64'd1);
    tick();
    idle_all();
    chk_bc("t6_b5", 1'b1, 5'd5);
    tick();
    chk_bc("t6_b8", 1'b1, 5'd8);
    tick();
    chk_bc("t6_b7", 1'b1, 5'd7);
    chk("t6_b7_data", 64'(BCdata), 64'h77);
    tick();
    chk_bc("t6_idle", 1'b0, 5'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
